// File: rtl/macc_pkg.sv
// Shared types and mux-select encodings for the MAC-array sequencer.
package macc_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        ADD  = 3'd2,
        RED  = 3'd3,
        ACC  = 3'd4,
        DONE = 3'd5
    } state_t;

    localparam logic       MUL_WEIGHT = 1'b0;

    localparam logic       ADD0_PROD  = 1'b0;
    localparam logic       ADD0_CHAIN = 1'b1;

    localparam logic [1:0] ADD1_ZERO  = 2'b00;
    localparam logic [1:0] ADD1_BUF   = 2'b01;
    localparam logic [1:0] ADD1_FB    = 2'b10;

    localparam logic [1:0] ACC_ZERO   = 2'b00;
    localparam logic [1:0] ACC_BUF    = 2'b01;
    localparam logic [1:0] ACC_FB     = 2'b10;

endpackage

// File: rtl/macc_seq_if.sv
// Command/operand handshake and array-control bundle between a host and the sequencer.
interface macc_seq_if #(
    parameter int NUM_PE = 16,
    parameter int CNT_W  = 8
);
    logic              start;
    logic [CNT_W-1:0]  num_chunks;
    logic              op_valid;
    logic              op_ready;
    logic [NUM_PE-1:0] en_mul;
    logic [NUM_PE-1:0] en_add;
    logic              en_acc;
    logic              mul_mux_sel;
    logic              add_mux0_sel;
    logic [1:0]        add_mux1_sel;
    logic [1:0]        acc_mux_sel;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  chunk_idx;

    modport master (
        output start, num_chunks, op_valid,
        input  op_ready, en_mul, en_add, en_acc, mul_mux_sel, add_mux0_sel,
               add_mux1_sel, acc_mux_sel, busy, done, chunk_idx
    );

    modport slave (
        input  start, num_chunks, op_valid,
        output op_ready, en_mul, en_add, en_acc, mul_mux_sel, add_mux0_sel,
               add_mux1_sel, acc_mux_sel, busy, done, chunk_idx
    );
endinterface

// File: rtl/macc_pe_onehot.sv
// Decodes the reduction step counter into a per-lane one-hot adder enable.
module macc_pe_onehot #(
    parameter int NUM_PE = 16,
    parameter int STEP_W = $clog2(NUM_PE)
) (
    input  logic              en,
    input  logic [STEP_W-1:0] step,
    output logic [NUM_PE-1:0] onehot
);
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PE; gi++) begin : g_lane
            assign onehot[gi] = en && (step == STEP_W'(gi));
        end
    endgenerate
endmodule

// File: rtl/macc_seq.sv
// Dot-product sequencer for an NUM_PE-lane MAC array (NUM_PE >= 2).
// Define MACC_SEQ_BIAS_EN to seed the accumulator with the buffered bias on chunk 0.
module macc_seq
    import macc_pkg::*;
#(
    parameter int NUM_PE = 16,
    parameter int CNT_W  = 8
) (
    input logic       clk,
    input logic       rstn,
    macc_seq_if.slave bus
);
    localparam int               STEP_W    = $clog2(NUM_PE);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_PE - 1);

`ifdef MACC_SEQ_BIAS_EN
    localparam logic [1:0] ACC_FIRST = ACC_BUF;
`else
    localparam logic [1:0] ACC_FIRST = ACC_ZERO;
`endif

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   chunk_reg, chunk_next;
    logic [CNT_W-1:0]   num_reg, num_next;
    logic [STEP_W-1:0]  step_reg, step_next;
    logic [NUM_PE-1:0]  red_onehot;

    macc_pe_onehot #(
        .NUM_PE (NUM_PE),
        .STEP_W (STEP_W)
    ) u_onehot (
        .en     (state_reg == RED),
        .step   (step_reg),
        .onehot (red_onehot)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
            chunk_reg <= '0;
            num_reg   <= '0;
            step_reg  <= '0;
        end else begin
            state_reg <= state_next;
            chunk_reg <= chunk_next;
            num_reg   <= num_next;
            step_reg  <= step_next;
        end
    end

    // All outputs decode from the registered state, so reset clears them at once.
    always_comb begin
        state_next       = state_reg;
        chunk_next       = chunk_reg;
        num_next         = num_reg;
        step_next        = step_reg;
        bus.op_ready     = 1'b0;
        bus.en_mul       = '0;
        bus.en_add       = '0;
        bus.en_acc       = 1'b0;
        bus.mul_mux_sel  = MUL_WEIGHT;
        bus.add_mux0_sel = ADD0_PROD;
        bus.add_mux1_sel = ADD1_ZERO;
        bus.acc_mux_sel  = ACC_ZERO;
        bus.done         = 1'b0;
        bus.busy         = (state_reg != IDLE);
        bus.chunk_idx    = chunk_reg;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    num_next   = bus.num_chunks;
                    chunk_next = '0;
                    state_next = (bus.num_chunks == '0) ? DONE : MUL;
                end
            end
            MUL: begin
                bus.op_ready = bus.op_valid;
                if (bus.op_valid) begin
                    bus.en_mul = '1;
                    state_next = ADD;
                end
            end
            ADD: begin
                bus.add_mux0_sel = ADD0_PROD;
                bus.add_mux1_sel = ADD1_ZERO;
                bus.en_add       = '1;
                step_next        = STEP_W'(1);
                state_next       = RED;
            end
            RED: begin
                // Lane k folds lane k-1 into itself; lane NUM_PE-1 ends with the chunk sum.
                bus.add_mux0_sel = ADD0_CHAIN;
                bus.add_mux1_sel = ADD1_FB;
                bus.en_add       = red_onehot;
                if (step_reg == LAST_STEP) begin
                    state_next = ACC;
                end else begin
                    step_next = step_reg + STEP_W'(1);
                end
            end
            ACC: begin
                bus.en_acc      = 1'b1;
                bus.acc_mux_sel = (chunk_reg == '0) ? ACC_FIRST : ACC_FB;
                if (chunk_reg == num_reg - CNT_W'(1)) begin
                    state_next = DONE;
                end else begin
                    chunk_next = chunk_reg + CNT_W'(1);
                    state_next = MUL;
                end
            end
            DONE: begin
                bus.done   = 1'b1;
                chunk_next = '0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_macc_seq.sv
// Randomized self-checking bench: expected control trace per job plus a behavioural MAC array.
module tb_macc_seq;
    localparam int NP      = 16;
    localparam int CW      = 8;
    localparam int BUF_VAL = 10;
`ifdef MACC_SEQ_BIAS_EN
    localparam int       BIAS_VAL  = 10;
    localparam bit [1:0] ACC0_EXP  = 2'b01;
`else
    localparam int       BIAS_VAL  = 0;
    localparam bit [1:0] ACC0_EXP  = 2'b00;
`endif

    typedef struct {
        bit          start;
        bit [CW-1:0] num;
        bit          opv;
        bit          load;
        int          chunk;
        bit          ready;
        bit [NP-1:0] en_mul;
        bit [NP-1:0] en_add;
        bit          en_acc;
        bit          add0;
        bit [1:0]    add1;
        bit [1:0]    accs;
        bit          busy;
        bit          done;
        bit [CW-1:0] cidx;
        int          idx;
    } rec_t;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    macc_seq_if #(.NUM_PE(NP), .CNT_W(CW)) bus ();

    macc_seq #(.NUM_PE(NP), .CNT_W(CW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    rec_t q[$];
    rec_t exp_r;
    bit   exp_valid = 0;
    int   job_ref = 0;
    bit   job_chk_acc = 0;
    int   done_cyc = -1;
    int   acc_at_done = 0;

    int act_m[8][NP];
    int wt_m[8][NP];
    int cur_act[NP];
    int cur_wt[NP];
    int mul_r[NP];
    int add_r[NP];
    int acc_r = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural MAC array steered purely by the DUT's enables and selects.
    always @(posedge clk) begin
        for (int i = 0; i < NP; i++) begin
            if (bus.en_mul[i]) mul_r[i] <= cur_act[i] * cur_wt[i];
            if (bus.en_add[i])
                add_r[i] <= (bus.add_mux0_sel ? ((i > 0) ? add_r[(i > 0) ? i - 1 : 0] : 0) : mul_r[i])
                          + ((bus.add_mux1_sel == 2'b10) ? add_r[i] :
                             (bus.add_mux1_sel == 2'b01) ? BUF_VAL : 0);
        end
        if (bus.en_acc)
            acc_r <= ((bus.acc_mux_sel == 2'b10) ? acc_r :
                      (bus.acc_mux_sel == 2'b01) ? BUF_VAL : 0) + add_r[NP-1];
    end

    // Compare process: every traced cycle, every output against the expected record.
    always @(negedge clk) begin
        if (exp_valid) begin
            chk("op_ready",     bus.op_ready,     exp_r.ready);
            chk("en_mul",       bus.en_mul,       exp_r.en_mul);
            chk("en_add",       bus.en_add,       exp_r.en_add);
            chk("en_acc",       bus.en_acc,       exp_r.en_acc);
            chk("mul_mux_sel",  bus.mul_mux_sel,  0);
            chk("add_mux0_sel", bus.add_mux0_sel, exp_r.add0);
            chk("add_mux1_sel", bus.add_mux1_sel, exp_r.add1);
            chk("acc_mux_sel",  bus.acc_mux_sel,  exp_r.accs);
            chk("busy",         bus.busy,         exp_r.busy);
            chk("done",         bus.done,         exp_r.done);
            chk("chunk_idx",    bus.chunk_idx,    exp_r.cidx);
            if (bus.done) begin
                done_cyc    = exp_r.idx;
                acc_at_done = acc_r;
                if (job_chk_acc) chk("acc_result", acc_r, job_ref);
            end
        end
    end

    task automatic check_zero(input string nm);
        chk({nm, "_op_ready"},  bus.op_ready,     0);
        chk({nm, "_en_mul"},    bus.en_mul,       0);
        chk({nm, "_en_add"},    bus.en_add,       0);
        chk({nm, "_en_acc"},    bus.en_acc,       0);
        chk({nm, "_selects"},   {bus.mul_mux_sel, bus.add_mux0_sel, bus.add_mux1_sel, bus.acc_mux_sel}, 0);
        chk({nm, "_busy"},      bus.busy,         0);
        chk({nm, "_done"},      bus.done,         0);
        chk({nm, "_chunk_idx"}, bus.chunk_idx,    0);
    endtask

    function automatic rec_t idle_rec();
        rec_t r;
        r     = '{default: 0};
        r.opv = 1'($urandom_range(0, 1));
        return r;
    endfunction

    // Inside a job, start and num_chunks toggle randomly and must have no effect.
    function automatic rec_t busy_rec(input int c);
        rec_t r;
        r       = '{default: 0};
        r.busy  = 1'b1;
        r.cidx  = CW'(c);
        r.chunk = c;
        r.start = ($urandom_range(0, 3) == 0);
        r.num   = CW'($urandom_range(0, 7));
        r.opv   = 1'($urandom_range(0, 1));
        return r;
    endfunction

    task automatic push(input rec_t r);
        r.idx = q.size();
        q.push_back(r);
    endtask

    // mode 0: act=1, weight=lane; mode 1: all 2; mode 2: random operands and stalls.
    task automatic run_job(input int n, input int mode, input int stall_c,
                           input int stall_len, input int abort_at);
        rec_t r;
        int   s;
        int   ref_sum = 0;
        q.delete();
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < NP; i++) begin
                case (mode)
                    0:       begin act_m[c][i] = 1; wt_m[c][i] = i; end
                    1:       begin act_m[c][i] = 2; wt_m[c][i] = 2; end
                    default: begin act_m[c][i] = int'($urandom_range(0, 15));
                                   wt_m[c][i]  = int'($urandom_range(0, 15)); end
                endcase
                ref_sum += act_m[c][i] * wt_m[c][i];
            end
        end
        if (n > 0) ref_sum += BIAS_VAL;

        r = idle_rec(); r.start = 1'b1; r.num = CW'(n); push(r);
        for (int c = 0; c < n; c++) begin
            s = (c == stall_c) ? stall_len : ((mode == 2) ? int'($urandom_range(0, 2)) : 0);
            for (int k = 0; k < s; k++) begin
                r = busy_rec(c); r.opv = 1'b0; push(r);
            end
            r = busy_rec(c); r.opv = 1'b1; r.ready = 1'b1; r.en_mul = '1; r.load = 1'b1; push(r);
            r = busy_rec(c); r.en_add = '1; push(r);
            for (int k = 1; k < NP; k++) begin
                r = busy_rec(c); r.add0 = 1'b1; r.add1 = 2'b10; r.en_add[k] = 1'b1; push(r);
            end
            r = busy_rec(c); r.en_acc = 1'b1; r.accs = (c == 0) ? ACC0_EXP : 2'b10; push(r);
        end
        r = busy_rec((n > 0) ? n - 1 : 0); r.done = 1'b1; push(r);
        r = idle_rec(); push(r);

        job_ref     = ref_sum;
        job_chk_acc = (n > 0);
        done_cyc    = -1;
        foreach (q[j]) begin
            @(posedge clk);
            #1;
            bus.start      = q[j].start;
            bus.num_chunks = q[j].num;
            bus.op_valid   = q[j].opv;
            if (q[j].load) begin
                for (int i = 0; i < NP; i++) begin
                    cur_act[i] = act_m[q[j].chunk][i];
                    cur_wt[i]  = wt_m[q[j].chunk][i];
                end
            end
            exp_r     = q[j];
            exp_valid = 1'b1;
            if (q[j].idx == abort_at) begin
                @(negedge clk);
                #1;
                exp_valid = 1'b0;
                $display("job n=%0d mode=%0d aborted at cycle %0d", n, mode, abort_at);
                return;
            end
        end
        @(negedge clk);
        #1;
        exp_valid = 1'b0;
        $display("job n=%0d mode=%0d done_cycle=%0d acc=%0d ref=%0d",
                 n, mode, done_cyc, acc_at_done, ref_sum);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn           = 1'b0;
        bus.start      = 1'b0;
        bus.num_chunks = '0;
        bus.op_valid   = 1'b0;
        for (int i = 0; i < NP; i++) begin
            cur_act[i] = 0; cur_wt[i] = 0; mul_r[i] = 0; add_r[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rstn = 1'b1;

        // Single chunk, act=1, weight=lane: sum 0..15.
        run_job(1, 0, -1, 0, -1);
        chk("lit_1chunk_done_cycle", done_cyc, 19);
        chk("lit_1chunk_acc", acc_at_done, 120 + BIAS_VAL);

        // Three chunks of all-2 operands.
        run_job(3, 1, -1, 0, -1);
        chk("lit_3chunk_done_cycle", done_cyc, 55);
        chk("lit_3chunk_acc", acc_at_done, 192 + BIAS_VAL);

        // Five-cycle operand stall in chunk 1.
        run_job(3, 1, 1, 5, -1);
        chk("lit_stall_done_cycle", done_cyc, 60);
        chk("lit_stall_acc", acc_at_done, 192 + BIAS_VAL);

        // Empty job goes straight to DONE.
        run_job(0, 1, -1, 0, -1);
        chk("lit_empty_done_cycle", done_cyc, 1);

        // Reset mid-reduction of chunk 0 must clear outputs without a clock edge.
        run_job(1, 0, -1, 0, 8);
        rstn = 1'b0;
        #1;
        check_zero("rst_mid");
        @(posedge clk);
        #1;
        check_zero("rst_hold");
        bus.start = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_zero("rst_after");
        end
        run_job(1, 0, -1, 0, -1);
        chk("lit_restart_done_cycle", done_cyc, 19);
        chk("lit_restart_acc", acc_at_done, 120 + BIAS_VAL);

        for (int j = 0; j < 15; j++) begin
            run_job(int'($urandom_range(0, 5)), 2, -1, 0, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/macc_seq.md
MACC_SEQ -- requirements
Module: macc_seq

Interface
REQ-001 Parameter NUM_PE, default 16, number of PE lanes in the controlled MAC array; SHALL be at least 2.
REQ-002 Parameter CNT_W, default 8, width of the chunk counter.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  job request; sampled only in IDLE.
REQ-006 num_chunks  input  CNT_W  number of NUM_PE-wide operand chunks in the dot product; latched when start is accepted.
REQ-007 op_valid  input  1  act/weight chunk present on the array inputs.
REQ-008 op_ready  output  1  chunk consumed this cycle.
REQ-009 en_mul  output  NUM_PE  per-PE multiplier register enable.
REQ-010 en_add  output  NUM_PE  per-PE adder register enable.
REQ-011 en_acc  output  1  accumulator register enable.
REQ-012 mul_mux_sel  output  1  multiplier operand select; SHALL be constant 0 (weight).
REQ-013 add_mux0_sel  output  1  0 = product, 1 = left-neighbour chain.
REQ-014 add_mux1_sel  output  2  00 = zero, 01 = buffer, 10 = feedback.
REQ-015 acc_mux_sel  output  2  00 = zero, 01 = buffer (bias), 10 = feedback.
REQ-016 busy  output  1  job in progress.
REQ-017 done  output  1  single-cycle completion pulse; the accumulator output holds the result in this cycle.
REQ-018 chunk_idx  output  CNT_W  index of the chunk being processed.

Function
REQ-019 States SHALL be IDLE, MUL, ADD, RED, ACC and DONE.
REQ-020 IDLE: the block SHALL drive all enables to 0 and all selects to 0; on start=1 it SHALL go to MUL, or to DONE when num_chunks=0.
REQ-021 MUL: op_ready SHALL equal op_valid; on op_valid=1 it SHALL set en_mul to all ones and go to ADD; otherwise it SHALL hold with all enables 0.
REQ-022 ADD: the block SHALL drive add_mux0_sel=0, add_mux1_sel=00 and en_add to all ones, then go to RED.
REQ-023 RED: the block SHALL drive add_mux0_sel=1 and add_mux1_sel=10 for NUM_PE-1 cycles; at step k (1..NUM_PE-1), en_add SHALL be one-hot at bit k, so that lane NUM_PE-1 ends with the chunk sum.
REQ-024 ACC: the block SHALL drive en_acc=1 with acc_mux_sel=10 for chunk_idx>0; chunk 0 selection is defined in REQ-032/033.
REQ-025 ACC exit: the block SHALL go to DONE if chunk_idx=num_chunks-1; otherwise it SHALL increment chunk_idx and go to MUL.
REQ-026 DONE: the block SHALL assert done=1 for exactly one cycle, then go to IDLE with chunk_idx cleared.
REQ-027 Latency: with op_valid held high, each chunk SHALL take NUM_PE+2 cycles; if start is accepted in cycle 0, done SHALL assert in cycle N*(NUM_PE+2)+1.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 start asserted while busy=1 SHALL be ignored; num_chunks SHALL be read only on acceptance.
REQ-030 The block SHALL assert no enable outside the cycles listed in REQ-021 to REQ-024; op_ready SHALL be 0 outside MUL.

Reset
REQ-031 rstn=0 SHALL immediately force IDLE, chunk_idx=0, busy=0, done=0, op_ready=0 and all enables and selects to 0, including mid-job; after release the block SHALL wait for a new start.

Configuration
REQ-032 Macro MACC_SEQ_BIAS_EN defined: chunk 0 ACC SHALL use acc_mux_sel=01, adding the bias from buffer lane NUM_PE.
REQ-033 Macro MACC_SEQ_BIAS_EN undefined: chunk 0 ACC SHALL use acc_mux_sel=00.

Structure
REQ-034 Shared package macc_pkg SHALL hold the state enum and localparams for the mux select encodings (ADD1_ZERO/BUF/FB, ACC_ZERO/BUF/FB).
REQ-035 One sub-module, macc_pe_onehot, SHALL generate the NUM_PE-wide one-hot en_add from the RED step counter.

Verification
REQ-036 NUM_PE=16, num_chunks=1, op_valid held 1, act=1, weight=lane index -> done in cycle 19; accumulator = 120.
REQ-037 num_chunks=3, all act=weight=2, bias undefined -> done in cycle 55; result = 192; chunk_idx sequence 0, 1, 2.
REQ-038 op_valid low for 5 cycles in MUL of chunk 1 -> op_ready=0 and no enables during the stall; done delayed by exactly 5 cycles; result unchanged.
REQ-039 num_chunks=0 -> done in cycle 1; no enable ever asserted.
REQ-040 rstn pulsed low during RED of chunk 0 -> all outputs 0 immediately; a restart gives the correct result; start pulsed during busy -> ignored.
REQ-041 MACC_SEQ_BIAS_EN defined, bias=10, REQ-036 stimulus -> result = 130; chunk 0 ACC uses acc_mux_sel=01.
